sw_input_ctrl: RTL

Memory-mapped input peripheral for the board's 16 slide switches: synchronises, debounces and edge-captures `sw_i[15:0]`, and exposes them to the CPU through the MIO bus as four 32-bit registers. It is the read-side counterpart to the 7-segment write path. The CPU polls switch state or sticky edge flags, or waits on a level interrupt, instead of sampling raw bouncing pins.

---
 rtl/sw_input_ctrl_pkg.sv | 20 ++
 rtl/sw_debounce_bit.sv | 54 +++++
 rtl/sw_input_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/sw_input_ctrl_pkg.sv
// Shared register map and widths for the slide-switch input peripheral.
package sw_input_ctrl_pkg;

  localparam int SW_BITS = 16;

  localparam logic [1:0] SW_REG_STATE = 2'd0;
  localparam logic [1:0] SW_REG_RISE  = 2'd1;
  localparam logic [1:0] SW_REG_FALL  = 2'd2;
  localparam logic [1:0] SW_REG_IRQEN = 2'd3;

  // Sticky flag update: a new event wins over a same-cycle write-one-to-clear.
  function automatic logic [SW_BITS-1:0] flag_update(
    input logic [SW_BITS-1:0] cur,
    input logic [SW_BITS-1:0] set,
    input logic [SW_BITS-1:0] clr
  );
    return (cur & ~clr) | set;
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchroniser, 3-deep tick sampler and debounced state.
module sw_debounce_bit (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sw,
  output logic db_state,
  output logic rise_evt,
  output logic fall_evt
);

  logic       sync1_r;
  logic       sync2_r;
  logic [2:0] smp_r;
  logic [2:0] smp_next_s;
  logic       db_state_r;
  logic       db_next_s;

  // Next sample window and debounced value; the state moves only on unanimous samples.
  always_comb begin
    smp_next_s = smp_r;
    db_next_s  = db_state_r;
    if (tick) begin
      smp_next_s = {smp_r[1:0], sync2_r};
      if ((smp_next_s == 3'b111) || (smp_next_s == 3'b000)) begin
        db_next_s = smp_next_s[0];
      end else begin
        db_next_s = db_state_r;
      end
    end else begin
      smp_next_s = smp_r;
    end
  end

  // Synchroniser, sample window and debounced state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      smp_r      <= 3'b000;
      db_state_r <= 1'b0;
    end else begin
      sync1_r    <= sw;
      sync2_r    <= sync1_r;
      smp_r      <= smp_next_s;
      db_state_r <= db_next_s;
    end
  end

  assign db_state = db_state_r;
  assign rise_evt = db_next_s & ~db_state_r;
  assign fall_evt = ~db_next_s & db_state_r;

endmodule

// File: rtl/sw_input_ctrl.sv
// Slide-switch input peripheral: debounced state, sticky edge flags and a masked
// level interrupt exposed as four 32-bit MIO registers.
module sw_input_ctrl
  import sw_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 1_000_000,
  parameter int CNT_W        = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW_BITS-1:0]  sw_i,
  input  logic [1:0]          addr,
  input  logic                wr_en,
  input  logic [31:0]         wr_data,
  output logic [31:0]         rd_data,
  output logic                irq
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic [CNT_W-1:0]   cnt_r;
  logic               tick_s;
  logic [1:0]         prime_cnt_r;
  logic               primed_s;
  logic [SW_BITS-1:0] db_state_s;
  logic [SW_BITS-1:0] rise_evt_s;
  logic [SW_BITS-1:0] fall_evt_s;
  logic [SW_BITS-1:0] rise_r;
  logic [SW_BITS-1:0] fall_r;
  logic [SW_BITS-1:0] mask_r;
  logic               irq_r;
  logic [SW_BITS-1:0] rise_clr_s;
  logic [SW_BITS-1:0] fall_clr_s;
  logic               mask_we_s;
  logic               unused_wr_hi_s;

  assign tick_s         = (cnt_r == TICK_LAST);
  assign primed_s       = (prime_cnt_r == 2'd3);
  assign unused_wr_hi_s = ^wr_data[31:16];

  for (genvar i = 0; i < SW_BITS; i++) begin : g_bit
    sw_debounce_bit u_bit (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick_s),
      .sw       (sw_i[i]),
      .db_state (db_state_s[i]),
      .rise_evt (rise_evt_s[i]),
      .fall_evt (fall_evt_s[i])
    );
  end

  // Register write decode.
  always_comb begin
    rise_clr_s = 16'h0000;
    fall_clr_s = 16'h0000;
    mask_we_s  = 1'b0;
    if (wr_en) begin
      case (addr)
        SW_REG_RISE:  rise_clr_s = wr_data[15:0];
        SW_REG_FALL:  fall_clr_s = wr_data[15:0];
        SW_REG_IRQEN: mask_we_s  = 1'b1;
        default:      mask_we_s  = 1'b0;
      endcase
    end else begin
      mask_we_s = 1'b0;
    end
  end

  // Tick counter and post-reset priming counter (saturates at 3).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= '0;
      prime_cnt_r <= 2'd0;
    end else begin
      if (tick_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (tick_s && !primed_s) begin
        prime_cnt_r <= prime_cnt_r + 2'd1;
      end
    end
  end

  // Sticky edge flags, interrupt mask and registered interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_r <= 16'h0000;
      fall_r <= 16'h0000;
      mask_r <= 16'h0000;
      irq_r  <= 1'b0;
    end else begin
      rise_r <= flag_update(rise_r, primed_s ? rise_evt_s : 16'h0000, rise_clr_s);
      fall_r <= flag_update(fall_r, primed_s ? fall_evt_s : 16'h0000, fall_clr_s);
      if (mask_we_s) begin
        mask_r <= wr_data[15:0];
      end
      irq_r <= |((rise_r | fall_r) & mask_r);
    end
  end

  // Read mux.
  always_comb begin
    rd_data = 32'h0000_0000;
    case (addr)
      SW_REG_STATE: rd_data = {16'h0000, db_state_s};
      SW_REG_RISE:  rd_data = {16'h0000, rise_r};
      SW_REG_FALL:  rd_data = {16'h0000, fall_r};
      SW_REG_IRQEN: rd_data = {16'h0000, mask_r};
      default:      rd_data = 32'h0000_0000;
    endcase
  end

  assign irq = irq_r;

endmodule
